// File: rtl/datapath.sv
// Accumulator-style datapath: a shared bus muxes one source into the register
// set each cycle; AC goes through a small ALU, AR/ARB drive the memory addresses.

module dp_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end
endmodule

module datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [13:0]       write_en,
  input  logic [3:0]        bus_ld,
  input  logic [1:0]        inc,
  input  logic [3:0]        clr,
  input  logic [3:0]        alu_mode,
  input  logic              dm_wr,
  input  logic              im_wr,
  input  logic              end_op,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              dmem_we,
  output logic              imem_we,
  output logic [7:0]        ir,
  output logic              z,
  output logic              done
);
  // Plain bus-loaded registers live in one packed array, indexed below.
  localparam int NGP = 10;
  localparam int I_DR = 0, I_IR = 1, I_R = 2, I_TR = 3, I_R1 = 4;
  localparam int I_R2 = 5, I_RI = 6, I_RJ = 7, I_RK = 8, I_R3 = 9;

  logic [NGP-1:0][DATA_W-1:0] gp_q;
  logic [NGP-1:0]             gp_ld, gp_clr;
  logic [DATA_W-1:0]          bus, alu, ac_q;
  logic [ADDR_W-1:0]          bus_a, ar_q, arb_q, pc_q;
  logic                       done_q;

  assign gp_ld = {write_en[0], write_en[1], write_en[2], write_en[3], write_en[4],
                  write_en[5], write_en[7], write_en[8], write_en[9], write_en[10]};

  always_comb begin
    gp_clr       = '0;
    gp_clr[I_R]  = clr[3];
    gp_clr[I_TR] = clr[1];
  end

  for (genvar g = 0; g < NGP; g++) begin : g_gp
    dp_reg #(.W(DATA_W)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (gp_clr[g]),
      .ld    (gp_ld[g]),
      .d     (bus),
      .q     (gp_q[g])
    );
  end

  always_comb begin
    case (bus_ld)
      4'd0:    bus = imem_rdata;
      4'd1:    bus = dmem_rdata;
      4'd2:    bus = DATA_W'(pc_q);
      4'd3:    bus = gp_q[I_DR];
      4'd4:    bus = gp_q[I_R];
      4'd5:    bus = ac_q;
      4'd6:    bus = gp_q[I_TR];
      4'd7:    bus = gp_q[I_R1];
      4'd8:    bus = gp_q[I_R2];
      4'd9:    bus = gp_q[I_RI];
      4'd10:   bus = gp_q[I_RJ];
      4'd11:   bus = gp_q[I_RK];
      4'd12:   bus = gp_q[I_R3];
      default: bus = '0;
    endcase
  end

  assign bus_a = ADDR_W'(bus);

  // Unused modes make a write_en[6] load a hold, which still beats inc[1].
  always_comb begin
    case (alu_mode)
      4'd0:    alu = ac_q + bus;
      4'd1:    alu = ac_q - bus;
      4'd2:    alu = ac_q * bus;
      4'd4:    alu = bus;
      default: alu = ac_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q  <= '0;
      ar_q   <= '0;
      pc_q   <= '0;
      ac_q   <= '0;
      done_q <= 1'b0;
    end else begin
      if (write_en[13]) arb_q <= bus_a;

      // AR without ARB is the fetch path: it copies the pre-edge PC.
      if (clr[0])            ar_q <= '0;
      else if (write_en[12]) ar_q <= write_en[13] ? bus_a : pc_q;

      if (clr[0])            pc_q <= '0;
      else if (write_en[11]) pc_q <= bus_a;
      else if (inc[0])       pc_q <= pc_q + ADDR_W'(1);

      if (clr[2])            ac_q <= '0;
      else if (write_en[6])  ac_q <= alu;
      else if (inc[1])       ac_q <= ac_q + DATA_W'(1);

      if (end_op) done_q <= 1'b1;
    end
  end

  assign imem_addr = ar_q;
  assign dmem_addr = arb_q;
  assign mem_wdata = bus;
  assign dmem_we   = dm_wr;
  assign imem_we   = im_wr;
  assign ir        = 8'(gp_q[I_IR]);
  assign z         = (ac_q == '0);
  assign done      = done_q;

endmodule
